fb_fill_engine: RTL and testbench
=================================

Name: fb_fill_engine

Overview:
- Write-side master for framebuffer port A; the mirror of the VGA controller, which reads port B.
- Accepts plot-pixel and fill-rectangle commands from the CPU/SoC bus over a valid/ready handshake.
- Clips each command to the screen and issues one 12-bit pixel write per clock.
- Can hold a command until vertical blank so the update does not tear, and pulses a done interrupt on completion.

Parameters:
FB_WIDTH, 320, framebuffer pixels per row (row stride in words)
FB_HEIGHT, 240, framebuffer rows
ADDR_W, 17, framebuffer address width
PIXEL_W, 12, pixel width (4:4:4 RGB)

Ports:
clock  in  1  single system clock; all logic on posedge
nreset  in  1  reset, synchronous, active-high (1 = reset)
cmd_valid  in  1  command present
cmd_ready  out  1  engine can accept a command (IDLE only)
cmd_op  in  1  0 = plot pixel, 1 = fill rectangle
cmd_sync  in  1  1 = wait for v_blank before the first write
cmd_x  in  9  left column
cmd_y  in  8  top row
cmd_w  in  9  width in pixels (ignored for plot)
cmd_h  in  8  height in rows (ignored for plot)
cmd_color  in  12  pixel value
v_blank  in  1  vertical blank level, from the VGA controller
fb_addr  out  17  port A address
fb_data  out  12  port A write data
fb_we  out  1  port A write enable
busy  out  1  1 in any state except IDLE
done_irq  out  1  one-cycle pulse when a command completes or is rejected
cmd_err  out  1  one-cycle pulse, coincident with done_irq, when a command was rejected

Behaviour:
- Reset values, and values every cycle while nreset=1: cmd_ready=0, busy=0, fb_we=0, fb_addr=0, fb_data=0, done_irq=0, cmd_err=0, state=IDLE.
- First cycle after nreset falls: cmd_ready=1.
- Reset mid-command aborts the command: no further writes and no done pulse.
- Handshake: a command is accepted on a clock edge where cmd_valid=1 and cmd_ready=1.
- On acceptance, all cmd_* fields are latched; later changes to cmd_* have no effect.
- cmd_ready is 0 from the cycle after acceptance until the engine returns to IDLE.
- Plot is executed as a fill with w=1, h=1.
- States:
  - IDLE: cmd_ready=1; on accept go to CHECK.
  - CHECK: if x>=FB_WIDTH or y>=FB_HEIGHT, go to DONE with cmd_err=1. If effective w=0 or h=0, go to DONE with no writes. Otherwise compute row_base = y*FB_WIDTH + x, ew = min(w, FB_WIDTH-x), eh = min(h, FB_HEIGHT-y), then go to WAIT_VB if sync=1, else FILL.
  - WAIT_VB: stay while v_blank=0; go to FILL on the first cycle v_blank=1. If v_blank is already 1 on entry, leave after 1 cycle.
  - FILL: fb_we=1 every cycle; fb_addr = row_base + col; fb_data = color.
    - col runs 0..ew-1.
    - At col=ew-1: col returns to 0, row_base += FB_WIDTH, row increments.
    - After writing the last pixel (row=eh-1, col=ew-1), go to DONE.
  - DONE: done_irq=1 for exactly 1 cycle (plus cmd_err if rejected), then IDLE.
- Timing, accept at edge N, no sync: CHECK in cycle N+1, writes in cycles N+2 .. N+1+ew*eh, done_irq in cycle N+2+ew*eh, cmd_ready=1 in cycle N+3+ew*eh.
- No back-to-back overlap: the next command is accepted no earlier than the edge after the DONE cycle.
- Arithmetic:
  - All address math is unsigned, ADDR_W bits.
  - Maximum address is 239*320+319 = 76799, so no wrap occurs within ADDR_W.
  - y*FB_WIDTH is computed once in CHECK; shift-add is acceptable for 320 (y<<8 + y<<6).
  - Clip comparisons use widths one bit wider than the operands to avoid overflow.
- v_blank is not sampled once FILL has started. A fill longer than the blank interval continues into active video by design.
- fb_we is only ever 1 in FILL, and only addresses inside the clipped rectangle are written.

Decomposition:
- Package fb_pkg:
  - FB_WIDTH, FB_HEIGHT, ADDR_W, PIXEL_W
  - OP_PLOT=0, OP_FILL=1
  - state encoding: IDLE, CHECK, WAIT_VB, FILL, DONE
- The VGA controller shares the geometry constants from fb_pkg.
- One sub-module, fb_rect_walker:
  - holds the col/row counters and the row_base accumulator;
  - inputs: load, base, ew, eh, step;
  - outputs: addr, last.
- The FSM, clipping and handshake stay in fb_fill_engine.

Test Plan:
- Reset: hold nreset=1 for 3 cycles, then release -> all outputs 0 during reset; cmd_ready=1 in the first cycle after release.
- Plot, x=5, y=2, color=0xF00, sync=0 -> exactly one write at addr 645, data 0xF00, 2 cycles after accept; done_irq 1 cycle later; cmd_err=0.
- Fill x=318, y=238, w=4, h=4 -> clipped to 2x2. Writes in order 76478, 76479, 76798, 76799; 4 consecutive fb_we cycles; then done_irq.
- Rejects and empties:
  - x=320 -> 0 writes; done_irq and cmd_err both pulse in the cycle after CHECK.
  - w=0, x=10 -> 0 writes; done_irq only.
- Sync: sync=1, v_blank=0 for 50 cycles, then 1 -> no fb_we before v_blank rises; first write 1 cycle after v_blank=1. With v_blank already 1 at accept, first write at N+3.
- Reset mid-fill: assert nreset during the 10th write of a 16x16 fill -> fb_we=0 from the next edge, no done_irq; a new plot accepted after release writes correctly.

Source files
------------

// File: rtl/fb_pkg.sv
// Framebuffer geometry, command opcodes and fill-engine state encoding.
// Shared with the VGA controller, which reads the same framebuffer.
package fb_pkg;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int ADDR_W    = 17;
    localparam int PIXEL_W   = 12;

    localparam logic OP_PLOT = 1'b0;
    localparam logic OP_FILL = 1'b1;

    typedef enum logic [2:0] {IDLE, CHECK, WAIT_VB, FILL, DONE} fill_state_t;

    // Row-major address y*320 + x, with the multiply by 320 done as (y<<8) + (y<<6).
    function automatic logic [ADDR_W-1:0] pixelAddr(input logic [7:0] y, input logic [8:0] x);
        return ({9'd0, y} << 8) + ({9'd0, y} << 6) + {8'd0, x};
    endfunction
endpackage

// File: rtl/fb_rect_walker.sv
// Walks a clipped rectangle in raster order: the column counter sweeps each row,
// then the row base address advances by one framebuffer stride.
module fb_rect_walker
    import fb_pkg::*;
(
    input  logic              clock,
    input  logic              nreset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [9:0]        ew,
    input  logic [9:0]        eh,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    logic [ADDR_W-1:0] rowBase_q, rowBase_d;
    logic [9:0]        col_q, col_d, ew_q, ew_d;
    logic [9:0]        row_q, row_d, eh_q, eh_d;
    logic              rowEnd;

    assign rowEnd = (col_q == ew_q - 10'd1);
    assign last   = rowEnd && (row_q == eh_q - 10'd1);
    assign addr   = rowBase_q + {7'd0, col_q};

    always_comb begin
        rowBase_d = rowBase_q;
        col_d     = col_q;
        row_d     = row_q;
        ew_d      = ew_q;
        eh_d      = eh_q;
        if (load) begin
            rowBase_d = base;
            col_d     = '0;
            row_d     = '0;
            ew_d      = ew;
            eh_d      = eh;
        end else if (step) begin
            if (rowEnd) begin
                col_d     = '0;
                row_d     = row_q + 10'd1;
                rowBase_d = rowBase_q + ADDR_W'(FB_WIDTH);
            end else begin
                col_d = col_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            rowBase_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            ew_q      <= '0;
            eh_q      <= '0;
        end else begin
            rowBase_q <= rowBase_d;
            col_q     <= col_d;
            row_q     <= row_d;
            ew_q      <= ew_d;
            eh_q      <= eh_d;
        end
    end
endmodule

// File: rtl/fb_fill_engine.sv
// Framebuffer port-A write master: accepts plot/fill commands, clips them to the
// screen, optionally waits for vertical blank, then writes one pixel per clock.
module fb_fill_engine
    import fb_pkg::*;
(
    input  logic               clock,
    input  logic               nreset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_op,
    input  logic               cmd_sync,
    input  logic [8:0]         cmd_x,
    input  logic [7:0]         cmd_y,
    input  logic [8:0]         cmd_w,
    input  logic [7:0]         cmd_h,
    input  logic [PIXEL_W-1:0] cmd_color,
    input  logic               v_blank,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [PIXEL_W-1:0] fb_data,
    output logic               fb_we,
    output logic               busy,
    output logic               done_irq,
    output logic               cmd_err
);
    fill_state_t        state_q;
    logic               op_q, sync_q, err_q;
    logic [8:0]         x_q, w_q;
    logic [7:0]         y_q, h_q;
    logic [PIXEL_W-1:0] color_q;

    logic [9:0]         wEff, hEff, xRoom, yRoom, ewClip, ehClip;
    logic               outOfRange, isEmpty;
    logic [ADDR_W-1:0]  walkAddr;
    logic               walkLast, walkLoad, walkStep;

    // Clip arithmetic is one bit wider than the operands so x near 511 cannot wrap.
    assign wEff       = (op_q == OP_FILL) ? {1'b0, w_q} : 10'd1;
    assign hEff       = (op_q == OP_FILL) ? {2'b0, h_q} : 10'd1;
    assign xRoom      = 10'(FB_WIDTH) - {1'b0, x_q};
    assign yRoom      = 10'(FB_HEIGHT) - {2'b0, y_q};
    assign ewClip     = (wEff < xRoom) ? wEff : xRoom;
    assign ehClip     = (hEff < yRoom) ? hEff : yRoom;
    assign outOfRange = ({1'b0, x_q} >= 10'(FB_WIDTH)) || ({2'b0, y_q} >= 10'(FB_HEIGHT));
    assign isEmpty    = (wEff == 10'd0) || (hEff == 10'd0);

    assign walkLoad = (state_q == CHECK) && !outOfRange && !isEmpty;
    assign walkStep = (state_q == FILL);

    fb_rect_walker walker (
        .clock  (clock),
        .nreset (nreset),
        .load   (walkLoad),
        .base   (pixelAddr(y_q, x_q)),
        .ew     (ewClip),
        .eh     (ehClip),
        .step   (walkStep),
        .addr   (walkAddr),
        .last   (walkLast)
    );

    // Outputs are decodes of the state register so they drop on the reset edge itself.
    assign cmd_ready = (state_q == IDLE) && !nreset;
    assign busy      = (state_q != IDLE);
    assign fb_we     = (state_q == FILL);
    assign fb_addr   = fb_we ? walkAddr : '0;
    assign fb_data   = fb_we ? color_q : '0;
    assign done_irq  = (state_q == DONE);
    assign cmd_err   = (state_q == DONE) && err_q;

    always_ff @(posedge clock) begin
        if (nreset) begin
            state_q <= IDLE;
            op_q    <= OP_PLOT;
            sync_q  <= 1'b0;
            err_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    err_q <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        op_q    <= cmd_op;
                        sync_q  <= cmd_sync;
                        x_q     <= cmd_x;
                        y_q     <= cmd_y;
                        w_q     <= cmd_w;
                        h_q     <= cmd_h;
                        color_q <= cmd_color;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (outOfRange) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (isEmpty) begin
                        state_q <= DONE;
                    end else begin
                        state_q <= sync_q ? WAIT_VB : FILL;
                    end
                end
                WAIT_VB: begin
                    if (v_blank) state_q <= FILL;
                end
                FILL: begin
                    if (walkLast) state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_fill_engine.sv
// Directed and randomised checks of fb_fill_engine against a pixel-list model that
// enumerates the on-screen pixels of each rectangle in raster order.
module tb_fb_fill_engine;
    import fb_pkg::*;

    logic        clock = 1'b0;
    logic        nreset, cmd_valid, cmd_op, cmd_sync, v_blank;
    logic        cmd_ready, fb_we, busy, done_irq, cmd_err;
    logic [8:0]  cmd_x, cmd_w;
    logic [7:0]  cmd_y, cmd_h;
    logic [11:0] cmd_color, fb_data;
    logic [16:0] fb_addr;

    int vectors = 0;
    int miscompares = 0;
    int gotAddr[$], gotData[$], gotCyc[$], expAddr[$];
    int doneCyc, doneCnt, readyCyc, errCnt, strayErr;

    fb_fill_engine dut (
        .clock     (clock),
        .nreset    (nreset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_sync  (cmd_sync),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .v_blank   (v_blank),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_we     (fb_we),
        .busy      (busy),
        .done_irq  (done_irq),
        .cmd_err   (cmd_err)
    );

    always #5 clock = ~clock;

    // Every on-screen pixel of the requested rectangle, row by row; off-screen origin rejects.
    function automatic void buildModel(input bit op, input int x, input int y,
                                       input int w, input int h, output bit rej);
        int ww;
        int hh;
        ww = op ? w : 1;
        hh = op ? h : 1;
        expAddr.delete();
        rej = (x >= FB_WIDTH) || (y >= FB_HEIGHT);
        if (!rej)
            for (int r = y; r < y + hh; r++)
                for (int c = x; c < x + ww; c++)
                    if (r < FB_HEIGHT && c < FB_WIDTH) expAddr.push_back(r * FB_WIDTH + c);
    endfunction

    // Issues one command and records every write, the done pulse and the return of
    // cmd_ready; cycle k counts clocks after the accept edge. v_blank is high from cycle vbRise.
    task automatic applyStimulus(input bit op, input bit sync, input int x, input int y,
                                 input int w, input int h, input logic [11:0] color, input int vbRise);
        gotAddr.delete();
        gotData.delete();
        gotCyc.delete();
        doneCyc = -1; doneCnt = 0; readyCyc = -1; errCnt = 0; strayErr = 0;
        @(negedge clock);
        v_blank   = (vbRise <= 0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sync  = sync;
        cmd_x     = 9'(x);
        cmd_y     = 8'(y);
        cmd_w     = 9'(w);
        cmd_h     = 8'(h);
        cmd_color = color;
        @(posedge clock);
        for (int k = 1; k < 3000; k++) begin
            @(negedge clock);
            if (fb_we === 1'b1) begin
                gotAddr.push_back(int'(fb_addr));
                gotData.push_back(int'(fb_data));
                gotCyc.push_back(k);
            end
            if (done_irq === 1'b1) begin
                doneCnt++;
                doneCyc = k;
                if (cmd_err === 1'b1) errCnt++;
            end else if (cmd_err === 1'b1) begin
                strayErr++;
            end
            if (doneCyc >= 0 && k > doneCyc && cmd_ready === 1'b1) begin
                readyCyc = k;
                break;
            end
            cmd_valid = 1'b0;
            cmd_op    = 1'($urandom);
            cmd_sync  = 1'($urandom);
            cmd_x     = 9'($urandom);
            cmd_y     = 8'($urandom);
            cmd_w     = 9'($urandom);
            cmd_h     = 8'($urandom);
            cmd_color = 12'($urandom);
            v_blank   = (k >= vbRise);
        end
    endtask

    task automatic test_reset();
        nreset = 1'b1;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_sync = 1'b0; v_blank = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        repeat (3) begin
            @(negedge clock);
            vectors++;
            if ({cmd_ready, busy, fb_we, done_irq, cmd_err, fb_addr, fb_data} !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs: got ready=%b busy=%b we=%b done=%b err=%b addr=%0d data=%0h, expected all 0",
                         cmd_ready, busy, fb_we, done_irq, cmd_err, fb_addr, fb_data);
            end
        end
        nreset = 1'b0;
        #1;
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got ready=%b busy=%b, expected ready=1 busy=0", cmd_ready, busy);
        end
    endtask

    task automatic test_plot();
        applyStimulus(1'b0, 1'b0, 5, 2, 0, 0, 12'hF00, 0);
        vectors++;
        if (gotAddr.size() !== 1) begin
            miscompares++;
            $display("[TB] FAIL plot_count: got %0d writes, expected 1", gotAddr.size());
        end else begin
            vectors++;
            if (gotAddr[0] !== 645 || gotData[0] !== 'hF00 || gotCyc[0] !== 2) begin
                miscompares++;
                $display("[TB] FAIL plot_write: got addr=%0d data=%0h cyc=%0d, expected addr=645 data=f00 cyc=2",
                         gotAddr[0], gotData[0], gotCyc[0]);
            end
        end
        vectors++;
        if (doneCyc !== 3 || doneCnt !== 1 || errCnt !== 0 || readyCyc !== 4) begin
            miscompares++;
            $display("[TB] FAIL plot_done: got done=%0d cnt=%0d err=%0d ready=%0d, expected done=3 cnt=1 err=0 ready=4",
                     doneCyc, doneCnt, errCnt, readyCyc);
        end
    endtask

    task automatic test_clip();
        int expClip[4] = '{76478, 76479, 76798, 76799};
        applyStimulus(1'b1, 1'b0, 318, 238, 4, 4, 12'h3C7, 0);
        vectors++;
        if (gotAddr.size() !== 4) begin
            miscompares++;
            $display("[TB] FAIL clip_count: got %0d writes, expected 4", gotAddr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (gotAddr[i] !== expClip[i] || gotData[i] !== 'h3C7 || gotCyc[i] !== 2 + i) begin
                    miscompares++;
                    $display("[TB] FAIL clip_write%0d: got addr=%0d data=%0h cyc=%0d, expected addr=%0d data=3c7 cyc=%0d",
                             i, gotAddr[i], gotData[i], gotCyc[i], expClip[i], 2 + i);
                end
            end
        end
        vectors++;
        if (doneCyc !== 6 || doneCnt !== 1 || errCnt !== 0) begin
            miscompares++;
            $display("[TB] FAIL clip_done: got done=%0d cnt=%0d err=%0d, expected done=6 cnt=1 err=0",
                     doneCyc, doneCnt, errCnt);
        end
    endtask

    task automatic test_reject();
        applyStimulus(1'b1, 1'b0, 320, 10, 5, 5, 12'h123, 0);
        vectors++;
        if (gotAddr.size() !== 0 || doneCyc !== 2 || doneCnt !== 1 || errCnt !== 1 || strayErr !== 0) begin
            miscompares++;
            $display("[TB] FAIL reject_x: got writes=%0d done=%0d cnt=%0d err=%0d stray=%0d, expected 0/2/1/1/0",
                     gotAddr.size(), doneCyc, doneCnt, errCnt, strayErr);
        end
        applyStimulus(1'b1, 1'b0, 10, 5, 0, 3, 12'h456, 0);
        vectors++;
        if (gotAddr.size() !== 0 || doneCyc !== 2 || doneCnt !== 1 || errCnt !== 0 || strayErr !== 0) begin
            miscompares++;
            $display("[TB] FAIL empty_w: got writes=%0d done=%0d cnt=%0d err=%0d stray=%0d, expected 0/2/1/0/0",
                     gotAddr.size(), doneCyc, doneCnt, errCnt, strayErr);
        end
    endtask

    task automatic test_sync();
        applyStimulus(1'b1, 1'b1, 100, 50, 3, 2, 12'h0F0, 52);
        vectors++;
        if (gotAddr.size() !== 6 || gotCyc.size() === 0 || gotCyc[0] !== 53 || doneCyc !== 59) begin
            miscompares++;
            $display("[TB] FAIL sync_wait: got writes=%0d first=%0d done=%0d, expected 6/53/59",
                     gotAddr.size(), (gotCyc.size() > 0) ? gotCyc[0] : -1, doneCyc);
        end
        applyStimulus(1'b1, 1'b1, 0, 0, 2, 1, 12'h00F, 0);
        vectors++;
        if (gotAddr.size() !== 2 || gotCyc.size() === 0 || gotCyc[0] !== 3 || doneCyc !== 5) begin
            miscompares++;
            $display("[TB] FAIL sync_ready: got writes=%0d first=%0d done=%0d, expected 2/3/5",
                     gotAddr.size(), (gotCyc.size() > 0) ? gotCyc[0] : -1, doneCyc);
        end
    endtask

    task automatic test_reset_mid_fill();
        int n;
        n = 0;
        @(negedge clock);
        v_blank = 1'b0; cmd_valid = 1'b1; cmd_op = 1'b1; cmd_sync = 1'b0;
        cmd_x = 9'd20; cmd_y = 8'd30; cmd_w = 9'd16; cmd_h = 8'd16; cmd_color = 12'hABC;
        @(posedge clock);
        for (int k = 1; k < 400 && n < 10; k++) begin
            @(negedge clock);
            cmd_valid = 1'b0;
            if (fb_we === 1'b1) n++;
        end
        vectors++;
        if (n !== 10) begin
            miscompares++;
            $display("[TB] FAIL midreset_writes: got %0d writes before reset, expected 10", n);
        end
        nreset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            vectors++;
            if (fb_we !== 1'b0 || done_irq !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midreset_abort: got we=%b done=%b busy=%b, expected 0/0/0", fb_we, done_irq, busy);
            end
        end
        nreset = 1'b0;
        applyStimulus(1'b0, 1'b0, 7, 9, 0, 0, 12'h0A5, 0);
        vectors++;
        if (gotAddr.size() !== 1 || gotAddr[0] !== 2887 || gotData[0] !== 'h0A5 || doneCyc !== 3) begin
            miscompares++;
            $display("[TB] FAIL midreset_replot: got writes=%0d addr=%0d done=%0d, expected 1/2887/3",
                     gotAddr.size(), (gotAddr.size() > 0) ? gotAddr[0] : -1, doneCyc);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            bit op, sync, rej;
            int x, y, w, h, vb, n, first, expDone;
            logic [11:0] color;
            op    = 1'($urandom);
            sync  = 1'($urandom);
            x     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 330)) : int'($urandom_range(0, 319));
            y     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(225, 245)) : int'($urandom_range(0, 239));
            w     = int'($urandom_range(0, 24));
            h     = int'($urandom_range(0, 10));
            vb    = int'($urandom_range(0, 8));
            color = 12'($urandom);
            buildModel(op, x, y, w, h, rej);
            applyStimulus(op, sync, x, y, w, h, color, vb);
            n       = expAddr.size();
            first   = sync ? (((vb > 2) ? vb : 2) + 1) : 2;
            expDone = (n == 0) ? 2 : first + n;
            vectors++;
            if (gotAddr.size() !== n) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_count: got %0d writes, expected %0d (op=%0d x=%0d y=%0d w=%0d h=%0d)",
                         t, gotAddr.size(), n, op, x, y, w, h);
            end
            for (int i = 0; i < n && i < gotAddr.size(); i++) begin
                vectors++;
                if (gotAddr[i] !== expAddr[i] || gotData[i] !== int'(color) || gotCyc[i] !== first + i) begin
                    miscompares++;
                    $display("[TB] FAIL rand%0d_write%0d: got addr=%0d data=%0h cyc=%0d, expected addr=%0d data=%0h cyc=%0d",
                             t, i, gotAddr[i], gotData[i], gotCyc[i], expAddr[i], color, first + i);
                end
            end
            vectors++;
            if (doneCyc !== expDone || doneCnt !== 1 || errCnt !== int'(rej) || strayErr !== 0 || readyCyc !== expDone + 1) begin
                miscompares++;
                $display("[TB] FAIL rand%0d_done: got done=%0d cnt=%0d err=%0d stray=%0d ready=%0d, expected done=%0d cnt=1 err=%0d stray=0 ready=%0d",
                         t, doneCyc, doneCnt, errCnt, strayErr, readyCyc, expDone, rej, expDone + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_plot();
        test_clip();
        test_reject();
        test_sync();
        test_reset_mid_fill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
